// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler
// Sequences one RS-485 response frame: captures the payload, clears and runs
// an external CRC unit, enables the line driver for a lead guard time, hands
// the payload bytes and the two CRC bytes to a UART transmitter one at a time,
// holds the driver for a tail guard time and reports done.
// A byte that never completes aborts the frame with an error pulse.

module uart_frame_scheduler #(
  parameter int PAYLOAD_BYTES  = 16,
  parameter int CRC_WAIT       = 4,
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       trigger,
  input  logic [PAYLOAD_BYTES*8-1:0] payload,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       overrun,
  output logic                       de_n,
  output logic                       crc_reset,
  output logic                       crc_calc,
  output logic [PAYLOAD_BYTES*8-1:0] crc_data,
  input  logic [15:0]                crc_in,
  output logic                       tx_start,
  output logic [7:0]                 tx_byte,
  input  logic                       tx_active,
  input  logic                       tx_done
);

  // Byte index spans payload bytes plus the two CRC bytes.
  localparam int IDX_W = $clog2(PAYLOAD_BYTES + 2);

  // One shared cycle counter serves the CRC wait, both guard times and the
  // per-byte timeout, so it is sized for the largest of them.
  localparam int CNT_MAX_A = (CRC_WAIT > GUARD_CYCLES) ? CRC_WAIT : GUARD_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CRC_LAST     = CNT_W'(CRC_WAIT);
  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(PAYLOAD_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE,
    CRC_CLR,
    CRC_RUN,
    LEAD,
    SEND,
    WAIT,
    TAIL
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           idx_next;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           cnt_next;
  logic [15:0]                crc_reg;
  logic [15:0]                crc_reg_next;
  logic [PAYLOAD_BYTES*8-1:0] crc_data_next;
  logic [7:0]                 tx_byte_next;

  // Frame byte i: payload bytes first, then CRC high byte, then CRC low byte.
  function automatic logic [7:0] byte_at(
    input logic [IDX_W-1:0]           i,
    input logic [PAYLOAD_BYTES*8-1:0] data,
    input logic [15:0]                crc
  );
    logic [7:0] b;
    b = 8'h00;
    for (int j = 0; j < PAYLOAD_BYTES; j++) begin
      if (i == IDX_W'(j)) begin
        b = data[8*j +: 8];
      end
    end
    if (i == IDX_W'(PAYLOAD_BYTES)) begin
      b = crc[15:8];
    end
    if (i == IDX_W'(PAYLOAD_BYTES + 1)) begin
      b = crc[7:0];
    end
    return b;
  endfunction

  // Next-state, datapath updates and the single-cycle strobes of the frame FSM.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    cnt_next      = cnt;
    crc_reg_next  = crc_reg;
    crc_data_next = crc_data;
    tx_byte_next  = tx_byte;
    done          = 1'b0;
    error         = 1'b0;
    crc_reset     = 1'b0;
    crc_calc      = 1'b0;
    tx_start      = 1'b0;

    case (state)
      IDLE: begin
        if (trigger) begin
          crc_data_next = payload;
          idx_next      = '0;
          cnt_next      = '0;
          state_next    = CRC_CLR;
        end
      end

      CRC_CLR: begin
        crc_reset  = 1'b1;
        cnt_next   = '0;
        state_next = CRC_RUN;
      end

      CRC_RUN: begin
        crc_calc = (cnt == '0);
        if (cnt == CRC_LAST) begin
          crc_reg_next = crc_in;
          cnt_next     = '0;
          state_next   = LEAD;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      LEAD: begin
        if (cnt == GUARD_LAST) begin
          idx_next     = '0;
          cnt_next     = '0;
          tx_byte_next = byte_at('0, crc_data, crc_reg);
          state_next   = SEND;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      SEND: begin
        if (!tx_active) begin
          tx_start   = 1'b1;
          cnt_next   = '0;
          state_next = WAIT;
        end
      end

      WAIT: begin
        // A completion arriving on the expiry cycle still counts as success.
        if (tx_done) begin
          cnt_next = '0;
          if (idx < IDX_LAST) begin
            idx_next     = idx + IDX_W'(1);
            tx_byte_next = byte_at(idx + IDX_W'(1), crc_data, crc_reg);
            state_next   = SEND;
          end else begin
            state_next = TAIL;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          error      = 1'b1;
          idx_next   = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      TAIL: begin
        if (cnt == GUARD_LAST) begin
          done       = 1'b1;
          idx_next   = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      default: begin
        idx_next   = '0;
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the current state; driver enabled LEAD..TAIL.
  always_comb begin
    busy = (state != IDLE);
    de_n = !((state == LEAD) || (state == SEND) || (state == WAIT) || (state == TAIL));
  end

  // State, index, counter and captured data registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      crc_reg  <= 16'h0000;
      crc_data <= '0;
      tx_byte  <= 8'h00;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      cnt      <= cnt_next;
      crc_reg  <= crc_reg_next;
      crc_data <= crc_data_next;
      tx_byte  <= tx_byte_next;
    end
  end

  // A trigger seen outside IDLE is dropped and reported one cycle later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overrun <= 1'b0;
    end else begin
      overrun <= trigger && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb_uart_frame_scheduler
// Directed bench for uart_frame_scheduler with a 2-byte payload, short guard
// times and a 50-cycle byte timeout. Small CRC and UART models drive the
// handshake inputs; every expected value below is worked out by hand.

module tb_uart_frame_scheduler;

  localparam int PAYLOAD_BYTES  = 2;
  localparam int CRC_WAIT       = 4;
  localparam int GUARD_CYCLES   = 4;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int UART_LEN       = 6;

  logic        CLK;
  logic        RST;
  logic        trigger;
  logic [15:0] payload;
  logic        busy;
  logic        done;
  logic        error;
  logic        overrun;
  logic        de_n;
  logic        crc_reset;
  logic        crc_calc;
  logic [15:0] crc_data;
  logic [15:0] crc_in;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        tx_done;

  int total = 0;
  int bad   = 0;

  int done_cnt = 0;
  int err_cnt  = 0;
  int ovr_cnt  = 0;

  logic [15:0] crc_value     = 16'h1234;
  bit          model_respond = 1'b1;
  bit          hold_active   = 1'b0;
  logic        m_active      = 1'b0;
  int          m_cnt         = 0;
  logic [7:0]  held_byte     = 8'h00;
  logic [7:0]  sent[$];

  uart_frame_scheduler #(
    .PAYLOAD_BYTES (PAYLOAD_BYTES),
    .CRC_WAIT      (CRC_WAIT),
    .GUARD_CYCLES  (GUARD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .trigger  (trigger),
    .payload  (payload),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .overrun  (overrun),
    .de_n     (de_n),
    .crc_reset(crc_reset),
    .crc_calc (crc_calc),
    .crc_data (crc_data),
    .crc_in   (crc_in),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .tx_active(tx_active),
    .tx_done  (tx_done)
  );

  assign tx_active = m_active | hold_active;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one trigger cycle with the given payload.
  task automatic apply_stimulus(input logic [15:0] pl);
    @(posedge CLK); #1;
    trigger = 1'b1;
    payload = pl;
    @(posedge CLK); #1;
    trigger = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    check_output(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp_bytes);
    logic [7:0] eb;
    check_output({tag, "_count"}, 32'(sent.size()), 32'd4);
    for (int i = 0; i < sent.size() && i < 4; i++) begin
      eb = exp_bytes[31-8*i -: 8];
      check_output($sformatf("%s_byte%0d", tag, i), 32'(sent[i]), 32'(eb));
    end
  endtask

  // CRC unit model: result valid exactly CRC_WAIT cycles after crc_calc.
  initial begin
    crc_in = 16'hDEAD;
    forever begin
      @(negedge CLK);
      if (crc_calc === 1'b1) begin
        repeat (CRC_WAIT) @(posedge CLK);
        #1 crc_in = crc_value;
        @(posedge CLK);
        #1 crc_in = 16'hDEAD;
      end
    end
  end

  // UART model: busy for UART_LEN cycles after tx_start, then tx_done pulse.
  initial begin
    bit start_seen;
    tx_done = 1'b0;
    forever begin
      @(negedge CLK);
      start_seen = (tx_start === 1'b1);
      if (start_seen) begin
        sent.push_back(tx_byte);
        held_byte = tx_byte;
      end else if (m_active && busy && !RST) begin
        check_output("tx_byte_hold", 32'(tx_byte), 32'(held_byte));
      end
      @(posedge CLK); #1;
      tx_done = 1'b0;
      if (start_seen) begin
        m_active = 1'b1;
        m_cnt    = UART_LEN;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_active = 1'b0;
          tx_done  = model_respond;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) err_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lead;
    int tail;
    int n;
    int k;
    int d0;
    int e0;
    int o0;
    bit seen;

    RST     = 1'b1;
    trigger = 1'b0;
    payload = 16'h0000;

    // Reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_error", 32'(error), 32'd0);
    check_output("rst_overrun", 32'(overrun), 32'd0);
    check_output("rst_de_n", 32'(de_n), 32'd1);
    check_output("rst_tx_start", 32'(tx_start), 32'd0);
    check_output("rst_tx_byte", 32'(tx_byte), 32'd0);
    check_output("rst_crc_reset", 32'(crc_reset), 32'd0);
    check_output("rst_crc_calc", 32'(crc_calc), 32'd0);
    check_output("rst_crc_data", 32'(crc_data), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Basic frame AA BB 12 34 with guard timing
    $display("[TB] basic frame");
    d0 = done_cnt;
    sent.delete();
    crc_value = 16'h1234;
    apply_stimulus(16'hBBAA);
    @(negedge CLK);
    check_output("clr_crc_reset", 32'(crc_reset), 32'd1);
    check_output("clr_busy", 32'(busy), 32'd1);
    check_output("clr_crc_data", 32'(crc_data), 32'hBBAA);
    check_output("clr_de_n", 32'(de_n), 32'd1);
    @(negedge CLK);
    check_output("run_crc_calc", 32'(crc_calc), 32'd1);
    check_output("run_crc_reset", 32'(crc_reset), 32'd0);
    lead = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (tx_start) seen = 1'b1;
      else if (!de_n) lead++;
    end
    check_output("first_start_seen", 32'(seen), 32'd1);
    check_output("lead_guard", 32'(lead), 32'd4);
    check_output("first_tx_byte", 32'(tx_byte), 32'hAA);
    tail = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      if (tx_done) tail = 0;
      else if (!de_n) tail++;
      if (done) seen = 1'b1;
    end
    check_output("basic_done_seen", 32'(seen), 32'd1);
    check_output("tail_guard", 32'(tail), 32'd4);
    @(negedge CLK);
    check_output("after_done_de_n", 32'(de_n), 32'd1);
    check_output("after_done_busy", 32'(busy), 32'd0);
    check_output("after_done_done", 32'(done), 32'd0);
    check_output("basic_done_once", 32'(done_cnt - d0), 32'd1);
    check_frame("basic", 32'hAABB1234);

    // Second trigger while busy is dropped
    $display("[TB] overrun");
    sent.delete();
    o0 = ovr_cnt;
    d0 = done_cnt;
    crc_value = 16'hC3E1;
    repeat (5) @(posedge CLK);
    apply_stimulus(16'h4433);
    repeat (14) @(posedge CLK);
    apply_stimulus(16'h6655);
    @(negedge CLK);
    check_output("ovr_pulse", 32'(overrun), 32'd1);
    check_output("ovr_busy", 32'(busy), 32'd1);
    check_output("ovr_crc_data", 32'(crc_data), 32'h4433);
    wait_done("ovr_done_seen");
    @(negedge CLK);
    check_output("ovr_count", 32'(ovr_cnt - o0), 32'd1);
    check_output("ovr_done_once", 32'(done_cnt - d0), 32'd1);
    check_frame("ovr", 32'h3344C3E1);

    // tx_active held high at the first SEND
    $display("[TB] tx_active hold");
    sent.delete();
    crc_value = 16'hABCD;
    @(posedge CLK); #1;
    hold_active = 1'b1;
    apply_stimulus(16'h2211);
    n = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge CLK);
      if (tx_start) n++;
    end
    check_output("hold_no_start", 32'(n), 32'd0);
    check_output("hold_de_n", 32'(de_n), 32'd0);
    @(posedge CLK); #1;
    hold_active = 1'b0;
    @(negedge CLK);
    check_output("hold_release_start", 32'(tx_start), 32'd1);
    check_output("hold_release_byte", 32'(tx_byte), 32'h11);
    wait_done("hold_done_seen");
    check_frame("hold", 32'h1122ABCD);

    // Byte never completes: timeout
    $display("[TB] timeout");
    repeat (3) @(posedge CLK);
    d0 = done_cnt;
    e0 = err_cnt;
    model_respond = 1'b0;
    crc_value = 16'h0F0F;
    apply_stimulus(16'h7788);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (tx_start) seen = 1'b1;
    end
    check_output("to_start_seen", 32'(seen), 32'd1);
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      k++;
      if (error) seen = 1'b1;
    end
    check_output("to_error_seen", 32'(seen), 32'd1);
    check_output("to_latency", 32'(k), 32'd50);
    check_output("to_no_done", 32'(done), 32'd0);
    @(negedge CLK);
    check_output("to_de_n", 32'(de_n), 32'd1);
    check_output("to_busy", 32'(busy), 32'd0);
    check_output("to_error_single", 32'(error), 32'd0);
    check_output("to_done_count", 32'(done_cnt - d0), 32'd0);
    check_output("to_error_count", 32'(err_cnt - e0), 32'd1);
    model_respond = 1'b1;
    repeat (10) @(posedge CLK);

    // Reset during the third byte's WAIT, then a clean frame
    $display("[TB] mid-frame reset");
    sent.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    crc_value = 16'h1234;
    apply_stimulus(16'hBBAA);
    n = 0;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(negedge CLK);
      if (tx_start) n++;
    end
    check_output("mr_third_start", 32'(n), 32'd3);
    @(posedge CLK); #1;
    #2 RST = 1'b1;
    #1;
    check_output("mr_de_n", 32'(de_n), 32'd1);
    check_output("mr_busy", 32'(busy), 32'd0);
    check_output("mr_tx_byte", 32'(tx_byte), 32'd0);
    check_output("mr_crc_data", 32'(crc_data), 32'd0);
    check_output("mr_tx_start", 32'(tx_start), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    check_output("mr_idle_busy", 32'(busy), 32'd0);
    check_output("mr_no_done", 32'(done_cnt - d0), 32'd0);
    check_output("mr_no_error", 32'(err_cnt - e0), 32'd0);
    sent.delete();
    apply_stimulus(16'hBBAA);
    wait_done("mr_done_seen");
    check_frame("mr", 32'hAABB1234);

    // Trigger in the done cycle (dropped) and the cycle after (accepted)
    $display("[TB] back-to-back");
    repeat (3) @(posedge CLK);
    sent.delete();
    crc_value = 16'h9876;
    apply_stimulus(16'hCDEF);
    n = 0;
    for (int i = 0; i < 300 && n < 4; i++) begin
      @(negedge CLK);
      if (tx_done) n++;
    end
    check_output("b2b_last_done", 32'(n), 32'd4);
    repeat (4) begin
      @(posedge CLK); #1;
    end
    trigger = 1'b1;
    payload = 16'h5566;
    @(negedge CLK);
    check_output("b2b_done_cycle", 32'(done), 32'd1);
    @(posedge CLK); #1;
    payload = 16'h1122;
    check_frame("b2b_a", 32'hEFCD9876);
    sent.delete();
    crc_value = 16'h3344;
    @(negedge CLK);
    check_output("b2b_overrun", 32'(overrun), 32'd1);
    check_output("b2b_idle", 32'(busy), 32'd0);
    check_output("b2b_data_kept", 32'(crc_data), 32'hCDEF);
    @(posedge CLK); #1;
    trigger = 1'b0;
    @(negedge CLK);
    check_output("b2b_crc_reset", 32'(crc_reset), 32'd1);
    check_output("b2b_crc_data", 32'(crc_data), 32'h1122);
    check_output("b2b_no_overrun", 32'(overrun), 32'd0);
    wait_done("b2b_done_seen");
    check_frame("b2b_b", 32'h22113344);

    repeat (2) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
